// File: rtl/pwm_pkg.sv
// pwm_pkg: shared encodings, widths and helpers for the PWM engine.
// Optional feature macro: PWM_CENTER_ALIGN_EN (center-aligned counting).
package pwm_pkg;

    localparam int PRESC_W = 4;
    localparam int DIV_W   = 16;

    typedef enum logic {
        PWM_MODE_EDGE   = 1'b0,
        PWM_MODE_CENTER = 1'b1
    } pwm_mode_e;

    // ceil(log2(v)), never below 1 so select fields stay at least 1 bit
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: one generator - prescaler, counter, shadow/active regs.
// PWM_CENTER_ALIGN_EN builds the direction flag and down-count path.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CH    = 2,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PRESC_W-1:0]  prescale_i,
    input  logic [CNT_W-1:0]    period_i,
    input  logic                mode_i,
    input  logic [CH*CNT_W-1:0] duty_i,
    input  logic                load_req_i,
    output logic                upd_pending_o,
    output logic                period_start_o,
    output logic [CH-1:0]       level_o
);

    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [CNT_W-1:0]    period_q, period_d;
    logic [CH*CNT_W-1:0] duty_q, duty_d;
    logic [DIV_W-1:0]    div_q, div_d, div_mask;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_nx;
    logic                pend_q, pend_d;
    logic                pstart_q, pstart_d;
    logic                tick, bnd, commit;
`ifdef PWM_CENTER_ALIGN_EN
    pwm_mode_e           mode_q, mode_d;
    logic                dir_q, dir_d, dir_nx;
`else
    logic                unused_mode;
    assign unused_mode = mode_i;
`endif

    assign div_mask = (DIV_W'(1) << presc_q) - DIV_W'(1);
    assign tick     = (div_q == div_mask);

    // counter value after the next tick (dir = 1 means counting down)
    always_comb begin
        cnt_nx = (cnt_q == period_q) ? '0 : cnt_q + CNT_W'(1);
`ifdef PWM_CENTER_ALIGN_EN
        dir_nx = 1'b0;
        if (mode_q == PWM_MODE_CENTER) begin
            if (period_q == '0) begin
                cnt_nx = '0;
            end else if (!dir_q && cnt_q < period_q) begin
                cnt_nx = cnt_q + CNT_W'(1);
            end else begin
                cnt_nx = cnt_q - CNT_W'(1);
                dir_nx = (cnt_nx != '0);
            end
        end
`endif
    end

    // boundary detection, pending tracking and commit of shadow inputs
    always_comb begin
        bnd      = tick && (cnt_nx == '0);
        commit   = bnd && (pend_q || load_req_i);
        pstart_d = bnd;
        pend_d   = (pend_q || load_req_i) && !commit;
        presc_d  = presc_q;
        period_d = period_q;
        duty_d   = duty_q;
        div_d    = tick ? '0 : div_q + DIV_W'(1);
        cnt_d    = tick ? cnt_nx : cnt_q;
`ifdef PWM_CENTER_ALIGN_EN
        mode_d   = mode_q;
        dir_d    = tick ? dir_nx : dir_q;
`endif
        if (commit) begin
            presc_d  = prescale_i;
            period_d = period_i;
            duty_d   = duty_i;
            div_d    = '0;
            cnt_d    = '0;
`ifdef PWM_CENTER_ALIGN_EN
            mode_d   = pwm_mode_e'(mode_i);
            dir_d    = 1'b0;
`endif
        end
    end

    // generator state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q  <= '0;
            period_q <= '0;
            duty_q   <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            pstart_q <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            mode_q   <= PWM_MODE_EDGE;
            dir_q    <= 1'b0;
`endif
        end else begin
            presc_q  <= presc_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            pstart_q <= pstart_d;
`ifdef PWM_CENTER_ALIGN_EN
            mode_q   <= mode_d;
            dir_q    <= dir_d;
`endif
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lvl
        assign level_o[c] = (cnt_q < duty_q[c*CNT_W +: CNT_W]);
    end

    assign upd_pending_o  = pend_q;
    assign period_start_o = pstart_q;

endmodule

// File: rtl/pwm_engine.sv
// pwm_engine: NUM_GEN timebases feeding a registered output crossbar.
// Optional feature macro: PWM_CENTER_ALIGN_EN (center-aligned counting).
module pwm_engine
    import pwm_pkg::*;
#(
    parameter  int NUM_GEN    = 2,
    parameter  int CH_PER_GEN = 2,
    parameter  int NUM_OUT    = 8,
    parameter  int CNT_W      = 8,
    localparam int NCH        = NUM_GEN * CH_PER_GEN,
    localparam int SEL_W      = clog2(NCH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PRESC_W*NUM_GEN-1:0]  gen_prescale,
    input  logic [CNT_W*NUM_GEN-1:0]    gen_period,
    input  logic [NUM_GEN-1:0]          gen_mode,
    input  logic [CNT_W*NCH-1:0]        duty,
    input  logic [NUM_GEN-1:0]          load_req,
    output logic [NUM_GEN-1:0]          upd_pending,
    output logic [NUM_GEN-1:0]          period_start,
    input  logic [NUM_OUT-1:0]          out_en,
    input  logic [NUM_OUT-1:0]          out_pwm_en,
    input  logic [SEL_W*NUM_OUT-1:0]    out_sel,
    input  logic [NUM_OUT-1:0]          out_inv,
    output logic [NUM_OUT-1:0]          out
);

    localparam int CW = CH_PER_GEN * CNT_W;

    logic [NCH-1:0]          level;
    logic [(1<<SEL_W)-1:0]   level_ext;
    logic [NUM_OUT-1:0]      out_d, out_q;

    for (genvar g = 0; g < NUM_GEN; g++) begin : g_gen
        pwm_timebase #(
            .CH    (CH_PER_GEN),
            .CNT_W (CNT_W)
        ) u_tb (
            .clk            (clk),
            .rst            (rst),
            .prescale_i     (gen_prescale[g*PRESC_W +: PRESC_W]),
            .period_i       (gen_period[g*CNT_W +: CNT_W]),
            .mode_i         (gen_mode[g]),
            .duty_i         (duty[g*CW +: CW]),
            .load_req_i     (load_req[g]),
            .upd_pending_o  (upd_pending[g]),
            .period_start_o (period_start[g]),
            .level_o        (level[g*CH_PER_GEN +: CH_PER_GEN])
        );
    end

    // crossbar: unused select codes read the zero padding above NCH
    always_comb begin
        out_d            = '0;
        level_ext        = '0;
        level_ext[NCH-1:0] = level;
        for (int p = 0; p < NUM_OUT; p++) begin
            if (!out_en[p]) begin
                out_d[p] = 1'b0;
            end else if (!out_pwm_en[p]) begin
                out_d[p] = 1'b1;
            end else begin
                out_d[p] = level_ext[out_sel[p*SEL_W +: SEL_W]] ^ out_inv[p];
            end
        end
    end

    // pin output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
    end

    assign out = out_q;

endmodule

// File: tb/tb_pwm_engine.sv
// tb_pwm_engine: directed + random stimulus against a time-based model.
// Build with PWM_CENTER_ALIGN_EN to match a center-aligned RTL build.
module tb_pwm_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  gen_prescale;
    logic [15:0] gen_period;
    logic [1:0]  gen_mode;
    logic [31:0] duty;
    logic [1:0]  load_req;
    logic [1:0]  upd_pending;
    logic [1:0]  period_start;
    logic [7:0]  out_en, out_pwm_en, out_inv;
    logic [15:0] out_sel;
    logic [7:0]  out;

    // shadow / pin stimulus
    logic [3:0] sh_psc  [2];
    logic [7:0] sh_per  [2];
    logic       sh_mode [2];
    logic [7:0] sh_duty [4];
    logic       ld      [2];
    logic       p_en [8], p_pw [8], p_inv [8];
    logic [1:0] p_sel [8];

    // reference model: active config + cycle of last restart
    int   a_p [2], a_per [2], a_mode [2], a_duty [4];
    int   s_cyc [2];
    logic m_pend [2];
    logic lv_prev [4];
    int   cyc = 0;
    int   n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            gen_prescale[g*4 +: 4] = sh_psc[g];
            gen_period[g*8 +: 8]   = sh_per[g];
            gen_mode[g]            = sh_mode[g];
            load_req[g]            = ld[g];
        end
        for (int c = 0; c < 4; c++) duty[c*8 +: 8] = sh_duty[c];
        for (int p = 0; p < 8; p++) begin
            out_en[p]         = p_en[p];
            out_pwm_en[p]     = p_pw[p];
            out_inv[p]        = p_inv[p];
            out_sel[p*2 +: 2] = p_sel[p];
        end
    end

    pwm_engine dut (
        .clk          (clk),
        .rst          (rst),
        .gen_prescale (gen_prescale),
        .gen_period   (gen_period),
        .gen_mode     (gen_mode),
        .duty         (duty),
        .load_req     (load_req),
        .upd_pending  (upd_pending),
        .period_start (period_start),
        .out_en       (out_en),
        .out_pwm_en   (out_pwm_en),
        .out_sel      (out_sel),
        .out_inv      (out_inv),
        .out          (out)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic bit center_on(input int g);
`ifdef PWM_CENTER_ALIGN_EN
        return a_mode[g] != 0;
`else
        return 1'b0;
`endif
    endfunction

    // counter value e clocks after a restart, from the waveform rules
    function automatic int mcnt(input int g, input int e);
        int t, per, ph;
        t   = e >> a_p[g];
        per = a_per[g];
        if (per == 0) return 0;
        if (center_on(g)) begin
            ph = t % (2 * per);
            return (ph <= per) ? ph : 2 * per - ph;
        end
        return t % (per + 1);
    endfunction

    function automatic logic [7:0] pins(input logic lv [4]);
        logic [7:0] r;
        for (int p = 0; p < 8; p++) begin
            if (!p_en[p])      r[p] = 1'b0;
            else if (!p_pw[p]) r[p] = 1'b1;
            else r[p] = ((p_sel[p] < 4) ? lv[p_sel[p]] : 1'b0) ^ p_inv[p];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            a_p[g] = 0; a_per[g] = 0; a_mode[g] = 0;
            s_cyc[g] = cyc; m_pend[g] = 1'b0;
        end
        for (int c = 0; c < 4; c++) begin
            a_duty[c] = 0; lv_prev[c] = 1'b0;
        end
    endtask

    task automatic step();
        logic [7:0] eo;
        logic [1:0] eps;
        logic [1:0] epend;
        logic       lv_now [4];
        int         e;
        bit         bnd;
        @(posedge clk);
        cyc++;
        eo = pins(lv_prev);
        for (int g = 0; g < 2; g++) begin
            e   = cyc - s_cyc[g];
            bnd = (e > 0) && (e % (1 << a_p[g]) == 0) && (mcnt(g, e) == 0);
            eps[g] = bnd;
            if (bnd && (m_pend[g] || ld[g])) begin
                a_p[g]    = int'(sh_psc[g]);
                a_per[g]  = int'(sh_per[g]);
                a_mode[g] = int'(sh_mode[g]);
                for (int k = 0; k < 2; k++)
                    a_duty[g*2+k] = int'(sh_duty[g*2+k]);
                s_cyc[g]  = cyc;
                m_pend[g] = 1'b0;
            end else begin
                m_pend[g] = m_pend[g] | ld[g];
            end
            epend[g] = m_pend[g];
        end
        for (int c = 0; c < 4; c++)
            lv_now[c] = (mcnt(c / 2, cyc - s_cyc[c / 2]) < a_duty[c]);
        #1;
        check("out", 32'(out), 32'(eo));
        check("upd_pending", 32'(upd_pending), 32'(epend));
        check("period_start", 32'(period_start), 32'(eps));
        lv_prev = lv_now;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input int g);
        ld[g] = 1'b1;
        step();
        ld[g] = 1'b0;
    endtask

    task automatic count_run(input int n, output int hi, output int ps);
        hi = 0;
        ps = 0;
        for (int i = 0; i < n; i++) begin
            step();
            hi += int'(out[0]);
            ps += int'(period_start[0]);
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_out", 32'(out), 32'd0);
        check("rst_upd", 32'(upd_pending), 32'd0);
        check("rst_pstart", 32'(period_start), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int hi, ps;
        for (int g = 0; g < 2; g++) begin
            sh_psc[g] = '0; sh_per[g] = '0; sh_mode[g] = 1'b0; ld[g] = 1'b0;
        end
        for (int c = 0; c < 4; c++) sh_duty[c] = '0;
        for (int p = 0; p < 8; p++) begin
            p_en[p] = 1'b0; p_pw[p] = 1'b0; p_inv[p] = 1'b0; p_sel[p] = '0;
        end
        p_en[0] = 1'b1;
        p_pw[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("init_out", 32'(out), 32'd0);
        check("init_upd", 32'(upd_pending), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // reset mid-period with a 50% waveform running
        sh_per[0] = 8'd9; sh_duty[0] = 8'd5;
        load(0);
        run(13);
        ld[0] = 1'b1;
        run(1);
        do_reset();
        ld[0] = 1'b0;
        run(20);

        // edge-aligned, period 10, duty 3
        sh_psc[0] = 4'd0; sh_per[0] = 8'd9; sh_duty[0] = 8'd3;
        load(0);
        run(12);
        count_run(30, hi, ps);
        check("edge_high", 32'(hi), 32'd9);
        check("edge_pstart", 32'(ps), 32'd3);

        // duty limits and pin controls
        sh_duty[0] = 8'd0;  load(0); run(25);
        sh_duty[0] = 8'd10; load(0); run(25);
        count_run(10, hi, ps);
        check("duty_full", 32'(hi), 32'd10);
        p_inv[0] = 1'b1; run(12);
        p_en[0] = 1'b0;  run(3);
        p_en[0] = 1'b1; p_pw[0] = 1'b0; run(3);
        p_pw[0] = 1'b1; p_inv[0] = 1'b0;

        // shadow duty change without load, then load mid-period
        sh_duty[0] = 8'd3; load(0); run(25);
        sh_duty[0] = 8'd7; run(24);
        load(0);
        run(25);
        count_run(20, hi, ps);
        check("shadow_high", 32'(hi), 32'd14);

        // prescaler 4, period 4 ticks
        sh_psc[0] = 4'd2; sh_per[0] = 8'd3; sh_duty[0] = 8'd2;
        load(0);
        run(20);
        count_run(32, hi, ps);
        check("presc_pstart", 32'(ps), 32'd2);

        // center-aligned request, period 4, duty 2
        sh_psc[0] = 4'd0; sh_per[0] = 8'd4; sh_duty[0] = 8'd2;
        sh_mode[0] = 1'b1;
        load(0);
        run(20);
        count_run(40, hi, ps);
`ifdef PWM_CENTER_ALIGN_EN
        check("center_high", 32'(hi), 32'd15);
        check("center_pstart", 32'(ps), 32'd5);
`else
        check("center_high", 32'(hi), 32'd16);
        check("center_pstart", 32'(ps), 32'd8);
`endif

        // randomized configuration and load traffic
        for (int p = 0; p < 8; p++) begin
            p_en[p]  = 1'($urandom);
            p_pw[p]  = 1'($urandom);
            p_inv[p] = 1'($urandom);
            p_sel[p] = 2'($urandom);
        end
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(7) == 0) begin
                int g;
                g = $urandom_range(1);
                sh_psc[g]  = 4'($urandom_range(2));
                sh_per[g]  = 8'($urandom_range(12));
                sh_mode[g] = 1'($urandom);
            end
            if ($urandom_range(5) == 0)
                sh_duty[$urandom_range(3)] = 8'($urandom_range(14));
            if ($urandom_range(31) == 0) begin
                int p;
                p = $urandom_range(7);
                p_en[p]  = 1'($urandom);
                p_pw[p]  = 1'($urandom);
                p_inv[p] = 1'($urandom);
                p_sel[p] = 2'($urandom);
            end
            ld[0] = ($urandom_range(19) == 0);
            ld[1] = ($urandom_range(19) == 0);
            step();
        end
        ld[0] = 1'b0;
        ld[1] = 1'b0;

        // reset in the middle of random operation
        do_reset();
        run(20);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_engine.md
# pwm_engine

Parametrised multi-generator PWM engine; next generation of the fixed 2-generator, 8-output, 8-bit PWM peripheral. Each generator has a power-of-two prescaler, a programmable period (TOP), optional center-aligned counting and double-buffered settings committed only at period boundaries. An output crossbar routes any channel to any pin with per-pin enable, PWM-enable and polarity inversion. Sits behind the SPI register file, which drives all configuration inputs directly.

## Interface
Parameters:
- NUM_GEN, 2, number of generators (timebases)
- CH_PER_GEN, 2, compare channels per generator
- NUM_OUT, 8, output pins
- CNT_W, 8, counter/period/duty width

Ports (NCH = NUM_GEN*CH_PER_GEN, SEL_W = clog2(NCH), minimum 1):
- clk  in  1  single clock for the whole block
- rst  in  1  asynchronous, active-high reset
- gen_prescale  in  4*NUM_GEN  divide exponent per generator (tick every 2^p clk)
- gen_period  in  CNT_W*NUM_GEN  TOP value per generator
- gen_mode  in  NUM_GEN  0 = edge-aligned, 1 = center-aligned
- duty  in  CNT_W*NCH  compare value per channel; channel index = gen*CH_PER_GEN + ch
- load_req  in  NUM_GEN  pulse: commit shadow inputs at next boundary
- upd_pending  out  NUM_GEN  load requested, not yet committed
- period_start  out  NUM_GEN  one-clk pulse on every boundary
- out_en  in  NUM_OUT  pin enable
- out_pwm_en  in  NUM_OUT  pin driven by PWM (else static high)
- out_sel  in  SEL_W*NUM_OUT  channel select per pin
- out_inv  in  NUM_OUT  invert PWM level per pin
- out  out  NUM_OUT  registered pin outputs

## Operation
- Per generator, active registers: prescale, period, mode, CH_PER_GEN duties. Inputs are shadows; they have no effect until committed.
- Prescaler: 16-bit div counter; tick when div == 2^p − 1, then div ← 0. p = 0: tick every clk. Exact divide-by-2^p.
- Edge mode: on tick, cnt ← (cnt == period) ? 0 : cnt+1. Period = period+1 ticks.
- Center mode: up from 0 to period, then down to 0; direction flag toggles at cnt == period (up) and cnt == 1 (down). Period = 2*period ticks. period = 0: cnt stays 0.
- Boundary: tick on which cnt becomes 0 (period 0: every tick).
- Channel level: cnt < duty_active. duty = 0 → constant 0; duty > period → constant 1.
- load_req sets upd_pending. At a boundary with pending (or load_req in the same clk): all active registers ← inputs, counter/div/direction restart from 0/up, upd_pending cleared. load_req without a boundary never changes active values.
- Pin: out = !out_en ? 0 : !out_pwm_en ? 1 : level[out_sel] ^ out_inv. out_sel ≥ NCH → level 0.

## Timing
- Reset (async assert, sync release): out = 0, upd_pending = 0, period_start = 0, all counters 0, direction up, active period 0, duty 0, prescale 0, mode 0. Reset mid-operation discards pending loads.
- Because active period resets to 0, the first load_req after reset commits on the next clk.
- out is registered: pin reflects cnt/level one clk later; static (non-PWM) pin changes also appear one clk after input change.
- period_start asserts in the clk the counter is 0 after a boundary; upd_pending falls in the same clk.
- load_req asserted on the boundary clk: committed at that boundary, upd_pending never rises.
- No glitches: only registered outputs leave the block.

## Configuration
- PWM_CENTER_ALIGN_EN defined: gen_mode honoured, direction flag and down-count logic built.
- Undefined: gen_mode ignored, all generators edge-aligned, no direction logic synthesised; port remains.

## Structure
- Package pwm_pkg: mode encodings (PWM_MODE_EDGE, PWM_MODE_CENTER), PRESC_W = 4, DIV_W = 16, clog2 function.
- Sub-module pwm_timebase: one generator (prescaler, counter, direction, shadow/active registers, pending, boundary, channel levels); instantiated NUM_GEN times. Crossbar and output registers in pwm_engine.

## Test plan
Defaults: NUM_GEN=2, CH_PER_GEN=2, CNT_W=8, NUM_OUT=8.
- Reset: run gen0 at duty 50%, assert rst mid-period → out, upd_pending, period_start 0 immediately; after release, outputs stay 0 until new load.
- Edge: gen0 p=0, period=9, duty0=3, load_req, pin0 sel 0 → out[0] high 3 of every 10 clk, period_start every 10 clk.
- Limits: duty0=0 → out[0] constant 0; duty0=10 with period 9 → constant 1; out_inv[0]=1 → levels inverted; out_en=0 → 0; out_pwm_en=0 → 1.
- Shadow: change duty0 3→7 with no load_req → waveform unchanged; load_req at cnt=4 → upd_pending high until next boundary, 7-high cycles from that period on.
- Prescale: p=2, period=3 → cnt advances every 4 clk, period_start every 16 clk.
- Center (macro defined): mode=1, period=4, duty=2 → cnt 0,1,2,3,4,3,2,1 repeating, out high 3 of 8 ticks; macro undefined → identical to edge mode, period 5 ticks.
